// File: rtl/bp_cce_dir_sharers_collect.sv
// Directory lookup front end: reads one LCE row per cycle for a way-group and builds the
// per-LCE sharers vectors (hits, ways, coherence states), then offers them via valid/yumi.
//
//   state | meaning
//   IDLE  | ready for a new (set, tag) lookup
//   READ  | strobing directory rows set*num_lce_p + 0 .. num_lce_p-1
//   DRAIN | no strobe; capturing the last row's RAM return
//   DONE  | sharers vectors valid, waiting for yumi
module bp_cce_dir_sharers_collect #(
    parameter int num_lce_p   = 4,
    parameter int lce_assoc_p = 8,
    parameter int num_sets_p  = 64,
    parameter int tag_width_p = 20,
    localparam int lce_assoc_width = $clog2(lce_assoc_p),
    localparam int sw              = $clog2(num_sets_p),
    localparam int ew              = tag_width_p + 3,
    localparam int addr_w          = $clog2(num_sets_p * num_lce_p),
    localparam int cnt_w           = $clog2(num_lce_p) + 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   v_i,
    output logic                                   ready_and_o,
    input  logic [sw-1:0]                          set_i,
    input  logic [tag_width_p-1:0]                 tag_i,
    output logic                                   dir_r_v_o,
    output logic [addr_w-1:0]                      dir_addr_o,
    input  logic [lce_assoc_p*ew-1:0]              dir_data_i,
    output logic                                   sharers_v_o,
    input  logic                                   sharers_yumi_i,
    output logic [num_lce_p-1:0]                   sharers_hits_o,
    output logic [num_lce_p*lce_assoc_width-1:0]   sharers_ways_o,
    output logic [num_lce_p*3-1:0]                 sharers_coh_states_o,
    output logic                                   multi_hit_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                             state_q, state_d;
    logic [sw-1:0]                          set_q, set_d;
    logic [tag_width_p-1:0]                 tag_q, tag_d;
    logic [cnt_w-1:0]                       rd_cnt_q, rd_cnt_d;
    logic [cnt_w-1:0]                       cap_cnt_q, cap_cnt_d;
    logic                                   pend_q, pend_d;
    logic [num_lce_p-1:0]                   hits_q, hits_d;
    logic [num_lce_p*lce_assoc_width-1:0]   ways_q, ways_d;
    logic [num_lce_p*3-1:0]                 states_q, states_d;
    logic                                   multi_q, multi_d;

    logic [lce_assoc_p-1:0]                 row_hit;
    logic                                   row_multi;
    logic [lce_assoc_width-1:0]             hit_way;
    logic [2:0]                             hit_state;

    assign ready_and_o          = (state_q == S_IDLE) & reset_n_i;
    assign dir_r_v_o            = (state_q == S_READ);
    assign dir_addr_o           = dir_r_v_o
                                  ? addr_w'(set_q) * addr_w'(num_lce_p) + addr_w'(rd_cnt_q)
                                  : '0;
    assign sharers_v_o          = (state_q == S_DONE);
    assign sharers_hits_o       = hits_q;
    assign sharers_ways_o       = ways_q;
    assign sharers_coh_states_o = states_q;
    assign multi_hit_o          = multi_q;

    // Descending scan so the lowest hitting way wins.
    always_comb begin
        row_hit   = '0;
        hit_way   = '0;
        hit_state = 3'd0;
        for (int w = 0; w < lce_assoc_p; w++) begin
            row_hit[w] = (dir_data_i[w*ew+3 +: tag_width_p] == tag_q)
                       && (dir_data_i[w*ew +: 3] != 3'd0);
        end
        for (int w = lce_assoc_p - 1; w >= 0; w--) begin
            if (row_hit[w]) begin
                hit_way   = lce_assoc_width'(w);
                hit_state = dir_data_i[w*ew +: 3];
            end
        end
        row_multi = (row_hit & (row_hit - 1'b1)) != '0;
    end

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        tag_d     = tag_q;
        rd_cnt_d  = rd_cnt_q;
        cap_cnt_d = cap_cnt_q;
        pend_d    = (state_q == S_READ);
        hits_d    = hits_q;
        ways_d    = ways_q;
        states_d  = states_q;
        multi_d   = multi_q;

        case (state_q)
            S_IDLE: begin
                if (v_i && ready_and_o) begin
                    set_d     = set_i;
                    tag_d     = tag_i;
                    hits_d    = '0;
                    ways_d    = '0;
                    states_d  = '0;
                    multi_d   = 1'b0;
                    rd_cnt_d  = '0;
                    cap_cnt_d = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == cnt_w'(num_lce_p - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (sharers_yumi_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Row data arrives one cycle after its strobe; pend_q marks that cycle.
        if (pend_q) begin
            for (int i = 0; i < num_lce_p; i++) begin
                if ((cap_cnt_q == cnt_w'(i)) && (|row_hit)) begin
                    hits_d[i]                                      = 1'b1;
                    ways_d[i*lce_assoc_width +: lce_assoc_width]   = hit_way;
                    states_d[i*3 +: 3]                             = hit_state;
                end
            end
            if (row_multi) begin
                multi_d = 1'b1;
            end
            cap_cnt_d = cap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            set_q     <= '0;
            tag_q     <= '0;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            pend_q    <= 1'b0;
            hits_q    <= '0;
            ways_q    <= '0;
            states_q  <= '0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            tag_q     <= tag_d;
            rd_cnt_q  <= rd_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            pend_q    <= pend_d;
            hits_q    <= hits_d;
            ways_q    <= ways_d;
            states_q  <= states_d;
            multi_q   <= multi_d;
        end
    end

endmodule

// File: tb/tb_bp_cce_dir_sharers_collect.sv
// Directed bench for bp_cce_dir_sharers_collect: a table of lookups against a behavioural
// directory RAM, plus reset-abort and held-DONE sequences.
module tb_bp_cce_dir_sharers_collect;

    localparam int NL = 4;
    localparam int NA = 8;
    localparam int TW = 20;
    localparam int EW = TW + 3;
    localparam int DW = NA * EW;
    localparam int AW = 8;

    localparam logic [2:0] COH_I = 3'b000;
    localparam logic [2:0] COH_S = 3'b010;
    localparam logic [2:0] COH_E = 3'b011;
    localparam logic [2:0] COH_M = 3'b110;
    localparam logic [2:0] COH_O = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v_i;
    logic          ready;
    logic [5:0]    set_i;
    logic [TW-1:0] tag_i;
    logic          dir_r_v;
    logic [AW-1:0] dir_addr;
    logic [DW-1:0] dir_data;
    logic          sv;
    logic          yumi;
    logic [NL-1:0] hits;
    logic [11:0]   ways;
    logic [11:0]   states;
    logic          mh;

    always #5 clk = ~clk;

    bp_cce_dir_sharers_collect dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .v_i                  (v_i),
        .ready_and_o          (ready),
        .set_i                (set_i),
        .tag_i                (tag_i),
        .dir_r_v_o            (dir_r_v),
        .dir_addr_o           (dir_addr),
        .dir_data_i           (dir_data),
        .sharers_v_o          (sv),
        .sharers_yumi_i       (yumi),
        .sharers_hits_o       (hits),
        .sharers_ways_o       (ways),
        .sharers_coh_states_o (states),
        .multi_hit_o          (mh)
    );

    logic [DW-1:0] mem [256];
    int            cyc = 0;
    int            strobe_addr[$];
    int            strobe_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dir_r_v) begin
            dir_data <= mem[dir_addr];
            strobe_addr.push_back(int'(dir_addr));
            strobe_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [5:0]           set;
        logic [TW-1:0]        tag;
        logic [3:0][DW-1:0]   rows;
        logic [3:0]           hits;
        logic [11:0]          ways;
        logic [11:0]          states;
        logic                 multi;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [DW-1:0] put(input logic [DW-1:0] row, input int way,
                                          input logic [TW-1:0] t, input logic [2:0] s);
        row[way*EW +: EW] = {t, s};
        return row;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i);
        for (int k = 0; k < 4; k++) mem[int'(vecs[i].set) * 4 + k] = vecs[i].rows[k];
    endtask

    task automatic accept(input logic [5:0] s, input logic [TW-1:0] t, output int acc);
        int n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_before_accept", ready, 1);
        set_i = s;
        tag_i = t;
        v_i   = 1'b1;
        acc   = cyc;
        strobe_addr.delete();
        strobe_cyc.delete();
        step();
        v_i = 1'b0;
    endtask

    task automatic wait_done(input int acc);
        int n = 0;
        while (!sv && n < 20) begin
            step();
            n++;
        end
        chk("sharers_v_latency", cyc - acc, 6);
    endtask

    task automatic check_vec(input int i, input int acc);
        chk("strobe_count", strobe_addr.size(), 4);
        for (int k = 0; k < 4 && k < strobe_addr.size(); k++) begin
            chk("strobe_addr", strobe_addr[k], int'(vecs[i].set) * 4 + k);
            chk("strobe_cycle", strobe_cyc[k], acc + 1 + k);
        end
        chk("hits", hits, vecs[i].hits);
        chk("ways", ways, vecs[i].ways);
        chk("states", states, vecs[i].states);
        chk("multi_hit", mh, vecs[i].multi);
    endtask

    task automatic do_yumi();
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        chk("ready_after_yumi", ready, 1);
        chk("sv_after_yumi", sv, 0);
    endtask

    initial begin
        int acc;
        int nstr;
        int bad_stable, bad_strobe, bad_ready;

        vecs[0].set = 6'd5;  vecs[0].tag = 20'hABCDE; vecs[0].rows = '0;
        vecs[0].rows[2] = put('0, 3, 20'hABCDE, COH_M);
        vecs[0].rows[0] = put('0, 0, 20'hABCDF, COH_M);
        vecs[0].hits = 4'b0100; vecs[0].ways = 12'h0C0; vecs[0].states = 12'h180; vecs[0].multi = 0;

        vecs[1].set = 6'd10; vecs[1].tag = 20'h12345; vecs[1].rows = '0;
        vecs[1].rows[0] = put('0, 1, 20'h12345, COH_S);
        vecs[1].rows[3] = put('0, 7, 20'h12345, COH_S);
        vecs[1].rows[1] = put('0, 0, 20'h12345, COH_I);
        vecs[1].hits = 4'b1001; vecs[1].ways = 12'hE01; vecs[1].states = 12'h402; vecs[1].multi = 0;

        vecs[2].set = 6'd33; vecs[2].tag = 20'h55AA5; vecs[2].rows = '0;
        vecs[2].rows[1] = put(put('0, 2, 20'h55AA5, COH_E), 5, 20'h55AA5, COH_E);
        vecs[2].hits = 4'b0010; vecs[2].ways = 12'h010; vecs[2].states = 12'h018; vecs[2].multi = 1;

        vecs[3].set = 6'd33; vecs[3].tag = 20'h0FFFF; vecs[3].rows = '0;
        vecs[3].rows[0] = put('0, 0, 20'h0FFFF, COH_M);
        vecs[3].hits = 4'b0001; vecs[3].ways = 12'h000; vecs[3].states = 12'h006; vecs[3].multi = 0;

        vecs[4].set = 6'd63; vecs[4].tag = 20'h00000; vecs[4].rows = '0;
        vecs[4].hits = 4'b0000; vecs[4].ways = 12'h000; vecs[4].states = 12'h000; vecs[4].multi = 0;

        vecs[5].set = 6'd1;  vecs[5].tag = 20'hFFFFF; vecs[5].rows = '0;
        vecs[5].rows[3] = put(put('0, 6, 20'hFFFFF, COH_O), 7, 20'hFFFFF, COH_M);
        vecs[5].hits = 4'b1000; vecs[5].ways = 12'hC00; vecs[5].states = 12'hE00; vecs[5].multi = 1;

        for (int a = 0; a < 256; a++) mem[a] = '0;
        // Reset-abort rows: every row hits tag 0 so a stale capture would show up.
        for (int k = 0; k < 4; k++) mem[20*4 + k] = put('0, 0, 20'h0, COH_M);

        rst_n = 1'b0; v_i = 1'b0; yumi = 1'b0; set_i = '0; tag_i = '0;
        step(); step();
        chk("rst_ready", ready, 0);
        chk("rst_dir_r_v", dir_r_v, 0);
        chk("rst_sv", sv, 0);
        chk("rst_hits", hits, 0);
        chk("rst_states", states, 0);
        chk("rst_multi", mh, 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", ready, 1);

        // Reset in the middle of READ after two strobes.
        accept(6'd20, 20'h0, acc);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        nstr = strobe_addr.size();
        chk("abort_dir_r_v", dir_r_v, 0);
        chk("abort_sv", sv, 0);
        chk("abort_ready_in_reset", ready, 0);
        #2 rst_n = 1'b1;
        step();
        chk("abort_ready", ready, 1);
        step(); step();
        chk("abort_no_strobes", strobe_addr.size(), nstr);
        chk("abort_no_stale_hits", hits, 0);
        chk("abort_sv_low", sv, 0);

        for (int i = 0; i < 6; i++) begin
            load(i);
            accept(vecs[i].set, vecs[i].tag, acc);
            wait_done(acc);
            check_vec(i, acc);
            do_yumi();
        end

        // Held DONE with v_i asserted, then back-to-back accept right after yumi.
        load(0);
        load(1);
        accept(vecs[0].set, vecs[0].tag, acc);
        wait_done(acc);
        check_vec(0, acc);
        v_i = 1'b1; set_i = vecs[1].set; tag_i = vecs[1].tag;
        bad_stable = 0; bad_strobe = 0; bad_ready = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (hits !== vecs[0].hits || ways !== vecs[0].ways || states !== vecs[0].states || sv !== 1'b1)
                bad_stable++;
            if (dir_r_v !== 1'b0) bad_strobe++;
            if (ready !== 1'b0) bad_ready++;
        end
        chk("hold_stable", bad_stable, 0);
        chk("hold_no_strobe", bad_strobe + strobe_addr.size(), 4);
        chk("hold_ready_low", bad_ready, 0);
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        chk("b2b_ready", ready, 1);
        acc = cyc;
        strobe_addr.delete();
        strobe_cyc.delete();
        step();
        v_i = 1'b0;
        chk("b2b_strobe", dir_r_v, 1);
        chk("b2b_addr", dir_addr, 8'd40);
        wait_done(acc);
        check_vec(1, acc);
        do_yumi();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
